// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared types and constants for the truth-table sweep controller
package simple_pkg;

  localparam int N_VECT = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tv_state_t;

endpackage

// File: rtl/tabla_verdad_if.sv
// rtl/tabla_verdad_if.sv - host-side control and result bundle of the sweep controller
interface tabla_verdad_if;
  import simple_pkg::*;

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [N_VECT-1:0] res_x;
  logic [N_VECT-1:0] res_y;
  logic [N_VECT-1:0] err_mask;
  logic              error;

  modport master (
    output start, abort,
    input  busy, done, res_x, res_y, err_mask, error
  );

  modport slave (
    input  start, abort,
    output busy, done, res_x, res_y, err_mask, error
  );

endinterface

// File: rtl/contador_espera.sv
// rtl/contador_espera.sv - loadable down-counter that saturates at zero
module contador_espera #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tabla_verdad_ctrl.sv
// rtl/tabla_verdad_ctrl.sv - steps {a,b,c} through all 8 vectors, samples x/y and flags mismatches
module tabla_verdad_ctrl
  import simple_pkg::*;
#(
  parameter int               DWELL = 10,
  parameter logic [N_VECT-1:0] EXP_X = 8'h00,
  parameter logic [N_VECT-1:0] EXP_Y = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  tabla_verdad_if.slave  ctl,
  input  logic           x,
  input  logic           y,
  output logic           a,
  output logic           b,
  output logic           c
);

  localparam int            CW       = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VECT - 1);

  tv_state_t         state;
  logic [IDX_W-1:0]  idx;
  logic [N_VECT-1:0] res_x;
  logic [N_VECT-1:0] res_y;
  logic [N_VECT-1:0] err_mask;
  logic              error;
  logic              cnt_load;
  logic              cnt_zero;
  logic              accept;
  logic              running;

  assign accept  = (state == ST_IDLE) && ctl.start && !ctl.abort;
  assign running = (state == ST_SETTLE) || (state == ST_SAMPLE);

  // Reload the dwell counter on every entry into SETTLE.
  assign cnt_load = accept ||
                    ((state == ST_SAMPLE) && !ctl.abort && (idx != LAST_IDX));

  contador_espera #(
    .W (CW)
  ) u_espera (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      res_x    <= '0;
      res_y    <= '0;
      err_mask <= '0;
      error    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_SETTLE;
            idx      <= '0;
            res_x    <= '0;
            res_y    <= '0;
            err_mask <= '0;
            error    <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (ctl.abort) begin
            state <= ST_IDLE;
          end else if (cnt_zero) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // An abort here wins over the capture of the current vector.
          if (ctl.abort) begin
            state <= ST_IDLE;
          end else begin
            res_x[idx]    <= x;
            res_y[idx]    <= y;
            err_mask[idx] <= (x != EXP_X[idx]) | (y != EXP_Y[idx]);
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          error <= |err_mask;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign {a, b, c}    = running ? idx : 3'b000;
  assign ctl.busy     = running;
  assign ctl.done     = (state == ST_DONE);
  assign ctl.res_x    = res_x;
  assign ctl.res_y    = res_y;
  assign ctl.err_mask = err_mask;
  assign ctl.error    = error;

endmodule

// File: tb/tb_tabla_verdad_ctrl.sv
// tb/tb_tabla_verdad_ctrl.sv - randomized self-checking bench for tabla_verdad_ctrl
module tb_tabla_verdad_ctrl;

  localparam logic [7:0] EXP_X = 8'hE8;  // majority(a,b,c)
  localparam logic [7:0] EXP_Y = 8'h96;  // a^b^c

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tabla_verdad_if if0 ();
  tabla_verdad_if if1 ();

  logic a0, b0, c0, x0, y0;
  logic a1, b1, c1, x1, y1;
  logic [7:0] tt_x, tt_y;
  logic start_r = 1'b0;
  logic abort_r = 1'b0;
  logic sel     = 1'b0;

  // Behavioural stand-in for the circuit under test: a programmable truth table.
  assign x0 = tt_x[{a0, b0, c0}];
  assign y0 = tt_y[{a0, b0, c0}];
  assign x1 = tt_x[{a1, b1, c1}];
  assign y1 = tt_y[{a1, b1, c1}];

  assign if0.start = start_r & ~sel;
  assign if0.abort = abort_r & ~sel;
  assign if1.start = start_r & sel;
  assign if1.abort = abort_r & sel;

  tabla_verdad_ctrl #(.DWELL(10), .EXP_X(EXP_X), .EXP_Y(EXP_Y)) u_dut10 (
    .clk(clk), .rst(rst), .ctl(if0), .x(x0), .y(y0), .a(a0), .b(b0), .c(c0)
  );

  tabla_verdad_ctrl #(.DWELL(1), .EXP_X(EXP_X), .EXP_Y(EXP_Y)) u_dut1 (
    .clk(clk), .rst(rst), .ctl(if1), .x(x1), .y(y1), .a(a1), .b(b1), .c(c1)
  );

  logic [2:0] m_abc;
  logic       m_busy, m_done, m_error;
  logic [7:0] m_resx, m_resy, m_err;
  assign m_abc   = sel ? {a1, b1, c1} : {a0, b0, c0};
  assign m_busy  = sel ? if1.busy     : if0.busy;
  assign m_done  = sel ? if1.done     : if0.done;
  assign m_error = sel ? if1.error    : if0.error;
  assign m_resx  = sel ? if1.res_x    : if0.res_x;
  assign m_resy  = sel ? if1.res_y    : if0.res_y;
  assign m_err   = sel ? if1.err_mask : if0.err_mask;

  int n_cmp = 0;
  int n_bad = 0;

  int done_cycle, done_cnt, abc_bad, busy_bad;
  logic err_at_done;

  // Start a sweep and watch it cycle by cycle. stop_k>0 asserts abort (or rst)
  // during cycle stop_k; rs1/rs2 re-pulse start during those cycles.
  task automatic sweep(input int dw, input int rs1, input int rs2,
                       input int stop_k, input bit stop_is_rst);
    int t, last, eabc;
    bit active, eb, ed;
    logic [2:0] eabc3;
    t = dw + 1;
    done_cycle = -1; done_cnt = 0; abc_bad = 0; busy_bad = 0; err_at_done = 1'bx;
    @(negedge clk); start_r = 1'b1; abort_r = 1'b0;
    @(negedge clk); start_r = 1'b0;
    last = (stop_k > 0) ? stop_k + 2 : 8 * t + 2;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) @(negedge clk);
      active = (stop_k == 0) || (k <= stop_k);
      if (active && k <= 8 * t) begin
        eb = 1'b1; ed = 1'b0; eabc = (k - 1) / t;
      end else if (active && k == 8 * t + 1) begin
        eb = 1'b0; ed = 1'b1; eabc = 0;
      end else begin
        eb = 1'b0; ed = 1'b0; eabc = 0;
      end
      eabc3 = eabc[2:0];
      if (m_abc !== eabc3) abc_bad++;
      if (m_busy !== eb) busy_bad++;
      if (m_done === 1'b1) begin
        done_cnt++; done_cycle = k; err_at_done = m_error;
      end
      if (ed && m_done !== 1'b1) busy_bad++;
      start_r = (k == rs1) || (k == rs2);
      abort_r = (k == stop_k) && !stop_is_rst;
      rst     = (k == stop_k) && stop_is_rst;
    end
    start_r = 1'b0; abort_r = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    tt_x = EXP_X; tt_y = EXP_Y;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", s, m_busy); end
      n_cmp++; if (m_done !== 1'b0) begin n_bad++; $display("FAIL reset_done[%0d]: got %b want 0", s, m_done); end
      n_cmp++; if (m_abc !== 3'b000) begin n_bad++; $display("FAIL reset_abc[%0d]: got %b want 000", s, m_abc); end
      n_cmp++; if ({m_resx, m_resy, m_err} !== 24'h0) begin n_bad++; $display("FAIL reset_res[%0d]: got %h want 000000", s, {m_resx, m_resy, m_err}); end
      n_cmp++; if (m_error !== 1'b0) begin n_bad++; $display("FAIL reset_error[%0d]: got %b want 0", s, m_error); end
    end
    sel = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_sweep(input string name, input int dw, input int rs1, input int rs2);
    logic [7:0] exp_err;
    int exp_done;
    exp_err  = (tt_x ^ EXP_X) | (tt_y ^ EXP_Y);
    exp_done = 8 * (dw + 1) + 1;
    sweep(dw, rs1, rs2, 0, 1'b0);
    n_cmp++; if (done_cycle !== exp_done) begin n_bad++; $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cycle, exp_done); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt); end
    n_cmp++; if (abc_bad !== 0) begin n_bad++; $display("FAIL %s_abc_seq: got %0d bad cycles want 0", name, abc_bad); end
    n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL %s_busy_seq: got %0d bad cycles want 0", name, busy_bad); end
    n_cmp++; if (m_resx !== tt_x) begin n_bad++; $display("FAIL %s_res_x: got %h want %h", name, m_resx, tt_x); end
    n_cmp++; if (m_resy !== tt_y) begin n_bad++; $display("FAIL %s_res_y: got %h want %h", name, m_resy, tt_y); end
    n_cmp++; if (m_err !== exp_err) begin n_bad++; $display("FAIL %s_err_mask: got %h want %h", name, m_err, exp_err); end
    n_cmp++; if (err_at_done !== 1'b0) begin n_bad++; $display("FAIL %s_error_in_done: got %b want 0", name, err_at_done); end
    n_cmp++; if (m_error !== (|exp_err)) begin n_bad++; $display("FAIL %s_error_after: got %b want %b", name, m_error, |exp_err); end
  endtask

  task automatic test_nominal();
    tt_x = EXP_X; tt_y = EXP_Y;
    test_full_sweep("nominal", 10, 0, 0);
  endtask

  task automatic test_error_bit5();
    tt_x = EXP_X ^ 8'h20; tt_y = EXP_Y;
    test_full_sweep("err_bit5", 10, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      tt_x = 8'($urandom); tt_y = 8'($urandom);
      test_full_sweep("random", 10, 0, 0);
    end
  endtask

  task automatic test_restart_ignored();
    tt_x = 8'($urandom); tt_y = 8'($urandom);
    test_full_sweep("restart", 10, 2 * 11 + 3, 7 * 11 + 1);
  endtask

  task automatic test_abort();
    logic [7:0] exp_err;
    tt_x = 8'($urandom); tt_y = 8'($urandom);
    exp_err = ((tt_x ^ EXP_X) | (tt_y ^ EXP_Y)) & 8'h07;
    sweep(10, 0, 0, 3 * 11 + 2, 1'b0);
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); end
    n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL abort_busy_seq: got %0d bad cycles want 0", busy_bad); end
    n_cmp++; if (abc_bad !== 0) begin n_bad++; $display("FAIL abort_abc_seq: got %0d bad cycles want 0", abc_bad); end
    n_cmp++; if (m_resx !== (tt_x & 8'h07)) begin n_bad++; $display("FAIL abort_res_x: got %h want %h", m_resx, tt_x & 8'h07); end
    n_cmp++; if (m_resy !== (tt_y & 8'h07)) begin n_bad++; $display("FAIL abort_res_y: got %h want %h", m_resy, tt_y & 8'h07); end
    n_cmp++; if (m_err !== exp_err) begin n_bad++; $display("FAIL abort_err_mask: got %h want %h", m_err, exp_err); end
    n_cmp++; if (m_error !== 1'b0) begin n_bad++; $display("FAIL abort_error: got %b want 0", m_error); end
  endtask

  task automatic test_start_abort_idle();
    logic [7:0] held_x;
    held_x = m_resx;
    @(negedge clk); start_r = 1'b1; abort_r = 1'b1;
    @(negedge clk); start_r = 1'b0; abort_r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL start_abort_busy: got %b want 0", m_busy); end
      @(negedge clk);
    end
    n_cmp++; if (m_resx !== held_x) begin n_bad++; $display("FAIL idle_hold_res_x: got %h want %h", m_resx, held_x); end
  endtask

  task automatic test_reset_mid();
    tt_x = 8'($urandom) | 8'h01; tt_y = 8'($urandom);
    sweep(10, 0, 0, 6 * 11, 1'b1);
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt); end
    n_cmp++; if (busy_bad !== 0 || abc_bad !== 0) begin n_bad++; $display("FAIL rstmid_idle: got %0d/%0d bad cycles want 0/0", busy_bad, abc_bad); end
    n_cmp++; if ({m_resx, m_resy, m_err, m_error} !== 25'h0) begin n_bad++; $display("FAIL rstmid_outputs: got %h want 0", {m_resx, m_resy, m_err, m_error}); end
    test_full_sweep("after_rst", 10, 0, 0);
  endtask

  task automatic test_dwell1();
    sel = 1'b1;
    tt_x = 8'($urandom); tt_y = 8'($urandom);
    test_full_sweep("dwell1", 1, 0, 0);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_error_bit5();
    test_random();
    test_abort();
    test_start_abort_idle();
    test_restart_ignored();
    test_reset_mid();
    test_dwell1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tabla_verdad_ctrl.md
TABLA_VERDAD_CTRL -- requirements
Module: tabla_verdad_ctrl

Interface
REQ-001 Parameter DWELL, default 10: clock cycles each input vector is held before X/Y are sampled; legal range 1..255.
REQ-002 Parameter EXP_X, default 8'h00: expected X for vector index i (bit i); the index is {A,B,C}.
REQ-003 Parameter EXP_Y, default 8'h00: expected Y for vector index i (bit i).
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 start  input  1  single-cycle request to run one full truth-table sweep.
REQ-007 abort  input  1  terminates a sweep in progress.
REQ-008 x, y  input  1 each  outputs of the circuito_simple instance under control.
REQ-009 a, b, c  output  1 each  drive A, B, C of circuito_simple.
REQ-010 busy  output  1  high while a sweep is running.
REQ-011 done  output  1  one-cycle pulse at the end of a completed sweep.
REQ-012 res_x, res_y  output  8 each  captured X/Y; bit i holds the sample for vector i.
REQ-013 err_mask  output  8  bit i set when vector i mismatches EXP_X or EXP_Y.
REQ-014 error  output  1  OR-reduction of err_mask, registered.

Function
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, DONE; reset state IDLE.
REQ-016 IDLE: start=1 and abort=0 -> SETTLE; idx<=0; dwell counter<=DWELL-1; res_x, res_y, err_mask, error cleared.
REQ-017 {a,b,c} SHALL equal idx[2:0] in SETTLE and SAMPLE, and 3'b000 in IDLE and DONE.
REQ-018 SETTLE: counter decrements each cycle; when counter==0, the next state is SAMPLE (DWELL cycles in SETTLE per vector).
REQ-019 SAMPLE: one cycle; res_x[idx]<=x; res_y[idx]<=y; err_mask[idx]<=(x!=EXP_X[idx])|(y!=EXP_Y[idx]).
REQ-020 SAMPLE with idx==7 -> DONE; otherwise idx<=idx+1, counter<=DWELL-1, next state SETTLE; idx does not wrap.
REQ-021 DONE: done=1 for exactly one cycle, error updated, next state IDLE.
REQ-022 Latency: done is high in the (8*(DWELL+1)+1)-th cycle after the edge that accepted start (89 cycles for DWELL=10).
REQ-023 busy=1 in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-024 start is ignored while busy=1 or in DONE; it is not queued.
REQ-025 abort=1 in SETTLE or SAMPLE -> IDLE next cycle; no done pulse; res_x, res_y, err_mask keep the vectors captured so far; error is not updated.
REQ-026 abort and start high together in IDLE: abort wins and no sweep starts.
REQ-027 res_x, res_y, err_mask and error hold their values in IDLE until the next accepted start.

Reset
REQ-028 rst=1 on a clock edge SHALL force IDLE with idx=0, counter=0, a=b=c=0, busy=0, done=0, res_x=res_y=err_mask=0 and error=0, from any state including mid-sweep.
REQ-029 rst has priority over start and abort.

Structure
REQ-030 Package simple_pkg SHALL hold the state enum tv_state_t, the constant N_VECT=8 and the constant IDX_W=3.
REQ-031 Dwell timing SHALL be implemented as sub-module contador_espera, with inputs load and load value and output zero flag, width $clog2(DWELL+1).
REQ-032 circuito_simple SHALL NOT be instantiated inside tabla_verdad_ctrl; the bench connects the two.

Verification
REQ-033 DWELL=10, EXP_X/EXP_Y set to circuito_simple's true truth table, start pulse -> a,b,c step 000..111 every 11 cycles; done at cycle 89; res matches EXP; err_mask=0; error=0.
REQ-034 Same as REQ-033 with EXP_X bit 5 flipped -> err_mask=8'h20; error=1 in the cycle after done.
REQ-035 abort during vector 3 SETTLE -> IDLE next cycle; busy=0; no done pulse; res bits 0..2 valid; bits 3..7 equal 0.
REQ-036 start re-pulsed at vectors 2 and 7 -> no restart; done still occurs at cycle 89.
REQ-037 rst asserted during vector 5 SAMPLE -> all outputs 0 on the next cycle; a new start then completes a normal sweep.
REQ-038 DWELL=1 -> each vector is held 2 cycles; done occurs at cycle 17.
